// File: rtl/bpu_pkg.sv
// bpu_pkg: shared widths, queue entry type and GHR shift helper for the predictor update path
package bpu_pkg;
   localparam int BPU_PC_W = 8;
   localparam int BPU_GHR_W = 8;
   typedef struct packed {
      logic [BPU_PC_W-1:0] pc;
      logic taken;
   } bpu_upd_t;
   function automatic logic [BPU_GHR_W-1:0] ghr_shift(input logic [BPU_GHR_W-1:0] g, input logic taken);
      return {g[BPU_GHR_W-2:0], taken};
   endfunction
endpackage

// File: rtl/bpu_upd_fifo.sv
// bpu_upd_fifo: dual-write single-read circular buffer; lane 1 is written ahead of lane 2 and excess writes are dropped
module bpu_upd_fifo
   import bpu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CW = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en_1,
   input  bpu_upd_t      wr_data_1,
   input  logic          wr_en_2,
   input  bpu_upd_t      wr_data_2,
   input  logic          rd_en,
   output bpu_upd_t      rd_data,
   output logic [CW-1:0] count,
   output logic          dropped
);
   localparam int PW = $clog2(DEPTH);
   bpu_upd_t mem [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] free;
   logic [1:0] n_push, written;
   bpu_upd_t first;
   always_comb begin
      n_push = {1'b0, wr_en_1} + {1'b0, wr_en_2};
      free = CW'(DEPTH) - count + CW'(rd_en);
      // free below n_push implies free < 2, so its low bits are the whole value
      written = (free >= CW'(n_push)) ? n_push : free[1:0];
      first = wr_en_1 ? wr_data_1 : wr_data_2;
      dropped = written != n_push;
   end
   assign rd_data = mem[rd_ptr];
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         count <= count + CW'(written) - CW'(rd_en);
         wr_ptr <= wr_ptr + PW'(written);
         rd_ptr <= rd_ptr + PW'(rd_en);
      end
   end
   always_ff @(posedge clk) begin
      if (written != 2'd0) mem[wr_ptr] <= first;
      if (written == 2'd2) mem[wr_ptr + PW'(1)] <= wr_data_2;
   end
endmodule

// File: rtl/bpu_update_scheduler.sv
// bpu_update_scheduler: orders execute-lane branch resolutions into the predictor update port and owns the committed GHR
module bpu_update_scheduler
   import bpu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PC_W = BPU_PC_W,
   parameter int GHR_W = BPU_GHR_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     br_valid_1,
   input  logic [PC_W-1:0]          br_pc_1,
   input  logic                     br_taken_1,
   input  logic                     br_valid_2,
   input  logic [PC_W-1:0]          br_pc_2,
   input  logic                     br_taken_2,
   output logic                     ex_stall,
   output logic                     upd_valid,
   input  logic                     upd_ready,
   output logic [PC_W-1:0]          upd_pc,
   output logic                     upd_taken,
   output logic [GHR_W-1:0]         upd_ghr,
   output logic [GHR_W-1:0]         ghr,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic                     overflow
);
   localparam int CW = $clog2(DEPTH) + 1;
   bpu_upd_t head, lane_1, lane_2;
   logic [CW-1:0] count;
   logic pop, dropped;
   assign lane_1 = '{pc: br_pc_1, taken: br_taken_1};
   assign lane_2 = '{pc: br_pc_2, taken: br_taken_2};
   bpu_upd_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .wr_en_1   (br_valid_1),
      .wr_data_1 (lane_1),
      .wr_en_2   (br_valid_2),
      .wr_data_2 (lane_2),
      .rd_en     (pop),
      .rd_data   (head),
      .count     (count),
      .dropped   (dropped)
   );
   assign upd_valid = count != '0;
   assign pop = upd_valid & upd_ready;
   assign upd_pc = head.pc;
   assign upd_taken = head.taken;
   assign upd_ghr = ghr;
   assign occupancy = count;
   // stall depends only on registered count so execute never sees a combinational loop
   assign ex_stall = count > CW'(DEPTH - 2);
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ghr <= '0;
         overflow <= 1'b0;
      end else begin
         if (pop) ghr <= ghr_shift(ghr, head.taken);
         if (dropped) overflow <= 1'b1;
      end
   end
endmodule

// File: tb/tb_bpu_update_scheduler.sv
// tb_bpu_update_scheduler: directed scenarios plus randomized traffic against a queue-based reference model
module tb_bpu_update_scheduler;
   localparam int DEPTH = 4;
   logic clk, reset;
   logic br_valid_1, br_taken_1, br_valid_2, br_taken_2, upd_ready;
   logic [7:0] br_pc_1, br_pc_2;
   logic ex_stall, upd_valid, upd_taken, overflow;
   logic [7:0] upd_pc, upd_ghr, ghr;
   logic [2:0] occupancy;
   int errors = 0, checks = 0;
   logic [8:0] mq [$];
   logic [7:0] mghr;
   logic movf;

   bpu_update_scheduler #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .br_valid_1(br_valid_1), .br_pc_1(br_pc_1), .br_taken_1(br_taken_1),
      .br_valid_2(br_valid_2), .br_pc_2(br_pc_2), .br_taken_2(br_taken_2),
      .ex_stall(ex_stall), .upd_valid(upd_valid), .upd_ready(upd_ready),
      .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_ghr(upd_ghr),
      .ghr(ghr), .occupancy(occupancy), .overflow(overflow)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic apply_reset();
      br_valid_1 = 0; br_valid_2 = 0; upd_ready = 0;
      br_pc_1 = 0; br_pc_2 = 0; br_taken_1 = 0; br_taken_2 = 0;
      @(posedge clk);
      #2 reset = 0;
      #2 reset = 1;
      mq.delete(); mghr = 0; movf = 0;
   endtask

   // drives one cycle of stimulus and advances the reference model past the edge
   task automatic step(input logic v1, input logic [7:0] p1, input logic t1,
                       input logic v2, input logic [7:0] p2, input logic t2, input logic rdy);
      br_valid_1 = v1; br_pc_1 = p1; br_taken_1 = t1;
      br_valid_2 = v2; br_pc_2 = p2; br_taken_2 = t2;
      upd_ready = rdy;
      @(posedge clk);
      if (rdy && mq.size() != 0) begin
         mghr = {mghr[6:0], mq[0][0]};
         void'(mq.pop_front());
      end
      if (v1) begin
         if (mq.size() < DEPTH) mq.push_back({p1, t1}); else movf = 1;
      end
      if (v2) begin
         if (mq.size() < DEPTH) mq.push_back({p2, t2}); else movf = 1;
      end
      #1;
   endtask

   task automatic test_reset();
      apply_reset();
      #1;
      checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
      checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", upd_valid); end
      checks++; if (ghr !== 8'h00) begin errors++; $display("FAIL reset_ghr got=%h exp=00", ghr); end
      checks++; if (ex_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", ex_stall); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
   endtask

   task automatic test_single_stream();
      apply_reset();
      step(1, 8'h10, 1, 0, 0, 0, 1);
      checks++; if (upd_valid !== 1 || upd_pc !== 8'h10 || upd_ghr !== 8'h00)
         begin errors++; $display("FAIL single_head1 got=%b/%h/%h exp=1/10/00", upd_valid, upd_pc, upd_ghr); end
      step(1, 8'h20, 0, 0, 0, 0, 1);
      checks++; if (upd_valid !== 1 || upd_pc !== 8'h20 || upd_ghr !== 8'h01)
         begin errors++; $display("FAIL single_head2 got=%b/%h/%h exp=1/20/01", upd_valid, upd_pc, upd_ghr); end
      step(0, 0, 0, 0, 0, 0, 1);
      checks++; if (ghr !== 8'h02 || occupancy !== 3'd0)
         begin errors++; $display("FAIL single_final got=%h/%0d exp=02/0", ghr, occupancy); end
   endtask

   task automatic test_dual_order();
      apply_reset();
      step(1, 8'h30, 0, 1, 8'h31, 1, 0);
      for (int i = 0; i < 3; i++) begin
         checks++; if (occupancy !== 3'd2 || upd_pc !== 8'h30 || upd_taken !== 1'b0)
            begin errors++; $display("FAIL dual_hold%0d got=%0d/%h exp=2/30", i, occupancy, upd_pc); end
         step(0, 0, 0, 0, 0, 0, 0);
      end
      step(0, 0, 0, 0, 0, 0, 1);
      checks++; if (occupancy !== 3'd1 || upd_pc !== 8'h31 || upd_taken !== 1'b1)
         begin errors++; $display("FAIL dual_second got=%0d/%h exp=1/31", occupancy, upd_pc); end
      step(0, 0, 0, 0, 0, 0, 1);
      checks++; if (ghr !== 8'h01 || upd_valid !== 1'b0)
         begin errors++; $display("FAIL dual_ghr got=%h/%b exp=01/0", ghr, upd_valid); end
   endtask

   task automatic test_fill_stall();
      apply_reset();
      step(1, 8'h50, 1, 1, 8'h51, 0, 0);
      checks++; if (occupancy !== 3'd2 || ex_stall !== 1'b0)
         begin errors++; $display("FAIL fill_2 got=%0d/%b exp=2/0", occupancy, ex_stall); end
      step(1, 8'h52, 1, 0, 0, 0, 0);
      checks++; if (occupancy !== 3'd3 || ex_stall !== 1'b1)
         begin errors++; $display("FAIL fill_3 got=%0d/%b exp=3/1", occupancy, ex_stall); end
      step(0, 0, 0, 1, 8'h53, 0, 0);
      checks++; if (occupancy !== 3'd4 || ex_stall !== 1'b1 || overflow !== 1'b0)
         begin errors++; $display("FAIL fill_4 got=%0d/%b/%b exp=4/1/0", occupancy, ex_stall, overflow); end
      step(1, 8'h54, 1, 1, 8'h55, 1, 0);
      checks++; if (occupancy !== 3'd4 || overflow !== 1'b1 || upd_pc !== 8'h50)
         begin errors++; $display("FAIL fill_drop got=%0d/%b/%h exp=4/1/50", occupancy, overflow, upd_pc); end
   endtask

   task automatic test_full_pop_push();
      logic [7:0] exp_pc [5];
      exp_pc = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h00};
      apply_reset();
      step(1, 8'h40, 0, 1, 8'h41, 1, 0);
      step(1, 8'h42, 0, 1, 8'h43, 1, 0);
      step(1, 8'h44, 1, 0, 0, 0, 1);
      checks++; if (occupancy !== 3'd4 || overflow !== 1'b0)
         begin errors++; $display("FAIL full_pp got=%0d/%b exp=4/0", occupancy, overflow); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (upd_valid !== 1'b1 || upd_pc !== exp_pc[i])
            begin errors++; $display("FAIL full_drain%0d got=%b/%h exp=1/%h", i, upd_valid, upd_pc, exp_pc[i]); end
         step(0, 0, 0, 0, 0, 0, 1);
      end
      checks++; if (occupancy !== 3'd0 || ghr !== 8'h0b)
         begin errors++; $display("FAIL full_end got=%0d/%h exp=0/0b", occupancy, ghr); end
   endtask

   task automatic test_reset_mid_drain();
      apply_reset();
      step(1, 8'h60, 1, 1, 8'h61, 0, 0);
      step(1, 8'h62, 1, 1, 8'h63, 0, 1);
      step(1, 8'h64, 0, 0, 0, 0, 1);
      step(1, 8'h65, 0, 0, 0, 0, 1);
      br_valid_1 = 0; upd_ready = 0;
      checks++; if (occupancy !== 3'd3 || ghr !== 8'h05)
         begin errors++; $display("FAIL mid_pre got=%0d/%h exp=3/05", occupancy, ghr); end
      #3 reset = 0;
      #1;
      checks++; if (occupancy !== 3'd0 || upd_valid !== 1'b0 || ghr !== 8'h00)
         begin errors++; $display("FAIL mid_async got=%0d/%b/%h exp=0/0/00", occupancy, upd_valid, ghr); end
      #2 reset = 1;
      mq.delete(); mghr = 0; movf = 0;
   endtask

   task automatic test_random();
      apply_reset();
      for (int n = 0; n < 400; n++) begin
         step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom),
              1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom),
              1'($urandom_range(0, 99) < 45));
         checks++;
         if (int'(occupancy) != mq.size() || upd_valid !== (mq.size() != 0) || ghr !== mghr ||
             upd_ghr !== mghr || overflow !== movf || ex_stall !== (mq.size() > DEPTH - 2)) begin
            errors++;
            $display("FAIL rand_state%0d got occ=%0d v=%b ghr=%h ovf=%b stall=%b exp occ=%0d ghr=%h ovf=%b",
                     n, occupancy, upd_valid, ghr, overflow, ex_stall, mq.size(), mghr, movf);
         end
         if (mq.size() != 0) begin
            checks++;
            if ({upd_pc, upd_taken} !== mq[0])
               begin errors++; $display("FAIL rand_head%0d got=%h exp=%h", n, {upd_pc, upd_taken}, mq[0]); end
         end
      end
   endtask

   initial begin
      reset = 0;
      test_reset();
      test_single_stream();
      test_dual_order();
      test_fill_stall();
      test_full_pop_push();
      test_reset_mid_drain();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/bpu_update_scheduler.md
Name: bpu_update_scheduler

Overview:
- Sequences resolved-branch updates from the two execute lanes into the single update port of the shared branch predictor.
- Queues resolutions in program order, lane 1 before lane 2 in the same cycle.
- Drains one update per accepted handshake and owns the single architectural global history register (GHR), which it advances in order.
- Sits between the execute stage and the predictor update port. Asserts a stall toward execute when it cannot take a full dual-issue pair.

Parameters:
- DEPTH, 4, queue entries; power of two, minimum 2.
- PC_W, 8, PC index width.
- GHR_W, 8, global history width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- br_valid_1  input  1  lane 1 (older) resolved branch this cycle.
- br_pc_1  input  PC_W  lane 1 branch PC.
- br_taken_1  input  1  lane 1 actual outcome.
- br_valid_2  input  1  lane 2 (younger) resolved branch this cycle.
- br_pc_2  input  PC_W  lane 2 branch PC.
- br_taken_2  input  1  lane 2 actual outcome.
- ex_stall  output  1  execute must hold; fewer than 2 free entries.
- upd_valid  output  1  head entry presented to the predictor.
- upd_ready  input  1  predictor accepts the head this cycle.
- upd_pc  output  PC_W  head PC.
- upd_taken  output  1  head outcome.
- upd_ghr  output  GHR_W  GHR value before this branch is shifted in (index hash input).
- ghr  output  GHR_W  current committed GHR.
- occupancy  output  $clog2(DEPTH)+1  number of valid entries.
- overflow  output  1  sticky: a resolution was dropped.

Behaviour:
- Reset values (asynchronous, on reset low):
  - count = 0, rd_ptr = 0, wr_ptr = 0, ghr = 0, overflow = 0.
  - Therefore upd_valid = 0, occupancy = 0, ex_stall = 0.
  - Entry storage is not reset.
- Storage: circular buffer of {pc, taken}; pointers wrap modulo DEPTH.
- pop = upd_valid & upd_ready.
- n_push = br_valid_1 + br_valid_2.
- Enqueue order:
  - If both lanes are valid, lane 1 goes to wr_ptr and lane 2 to wr_ptr+1.
  - If only one lane is valid, it goes to wr_ptr.
  - wr_ptr advances by the number of entries actually written.
- Space rule: free = DEPTH - count + pop. A pop in the same cycle frees a slot for a push.
- Drop rule:
  - If n_push > free, lane 1 is written first if it fits; entries that do not fit are dropped.
  - Any drop sets overflow. overflow clears only on reset.
- count_next = count + written - pop. It never exceeds DEPTH and never goes below 0.
- ex_stall = (count > DEPTH-2), from registered count only. It is combinational in no input.
- Output side:
  - upd_valid = (count != 0).
  - upd_pc and upd_taken are read from the entry at rd_ptr; outputs come straight from registers.
  - upd_ghr = ghr.
  - Head outputs hold stable while upd_valid & ~upd_ready.
- Pop effects: rd_ptr advances and ghr <= {ghr[GHR_W-2:0], upd_taken}. At most one pop per cycle.
- Latency:
  - A push at edge N is visible at the head after edge N (next cycle) if the queue was empty.
  - No same-cycle bypass from input to output.
- Boundary cases:
  - Empty with pop attempted: upd_valid = 0, so no pop occurs.
  - Full with a simultaneous pop and one push: both take effect and count is unchanged.
  - Pointer wrap past DEPTH-1 returns to 0 with order preserved.
- Reset mid-drain: the queue and GHR are discarded immediately and asynchronously.

Decomposition:
- Package bpu_pkg holds:
  - PC_W and GHR_W constants.
  - Typedef bpu_upd_t {pc, taken}.
  - Function ghr_shift(ghr, taken).
- Sub-module bpu_upd_fifo: dual-write, single-read circular buffer with count and free logic.
- The top level adds the GHR, stall, and overflow logic.

Test Plan:
- Reset then idle: occupancy = 0, upd_valid = 0, ghr = 0x00, ex_stall = 0.
- Single stream:
  - Stimulus: lane1 pc = 0x10 taken = 1, then pc = 0x20 taken = 0, with upd_ready = 1.
  - Required response: head shows 0x10/upd_ghr 0x00 one cycle after the push, then 0x20/upd_ghr 0x01; final ghr = 0x02.
- Dual-issue ordering:
  - Stimulus: one cycle with lane1 pc = 0x30 taken = 0 and lane2 pc = 0x31 taken = 1, upd_ready = 0 for 3 cycles, then 1.
  - Required response: occupancy = 2 and the head holds 0x30 while not ready; drain order is 0x30 then 0x31; ghr = 0x01.
- Fill and stall (DEPTH = 4, upd_ready = 0):
  - Stimulus: push 2 pairs.
  - Required response: ex_stall = 1 at occupancy = 3 and at 4. A further lane1 + lane2 push drops both and sets overflow; occupancy stays 4.
- Full with simultaneous pop and push:
  - Stimulus: occupancy = 4, upd_ready = 1, one lane1 push.
  - Required response: occupancy stays 4, overflow stays 0, and the new entry drains last after wrap.
- Reset mid-drain:
  - Stimulus: occupancy = 3 and ghr = 0x05; assert reset low between clock edges.
  - Required response: occupancy = 0, upd_valid = 0, ghr = 0x00 immediately, before the next edge.
